cu_array_cacheline_request_generator: RTL and testbench



---
 rtl/cu_array_cacheline_request_generator_pkg.sv | 35 +++
 rtl/cu_array_cacheline_request_generator_credit.sv | 44 ++++
 rtl/cu_array_cacheline_request_generator.sv | 138 +++++++++++++
 tb/tb_cu_array_cacheline_request_generator.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/cu_array_cacheline_request_generator_pkg.sv
// Shared CU definitions for the array cacheline request generator:
// line geometry helpers, the request record and the generator state encoding.
package cu_array_cacheline_request_generator_pkg;

    localparam logic [7:0] VERTEX_CONTROL_ID = 8'h01;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } req_gen_state_e;

    // Widest request record any legal parameterisation needs; instances slice it.
    typedef struct packed {
        logic [63:0] addr;
        logic [15:0] offset;
        logic [16:0] num;
        logic        last;
        logic [7:0]  cu_id;
    } cu_req_t;

    function automatic int unsigned line_elems(input int unsigned cacheline_size,
                                               input int unsigned element_size);
        return cacheline_size / element_size;
    endfunction

    function automatic logic [63:0] line_mod_mask(input int unsigned cacheline_size);
        return 64'(cacheline_size) - 64'd1;
    endfunction

    function automatic logic [63:0] line_align_mask(input int unsigned cacheline_size);
        return ~line_mod_mask(cacheline_size);
    endfunction

endpackage

// File: rtl/cu_array_cacheline_request_generator_credit.sv
// Outstanding-request credit counter: counts issued-but-unanswered requests
// and flags (stickily) any response that arrives with nothing outstanding.
module cu_outstanding_credit_counter #(
    parameter  int MAX_OUTSTANDING = 16,
    localparam int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] count_next,
    output logic             full,
    output logic             underflow_error
);

    logic dec_ok;

    assign dec_ok = dec && (count != '0);
    assign full   = (count == CNT_W'(MAX_OUTSTANDING));

    always_comb begin
        // NOTE: default assignment first so no path through the case infers a latch.
        count_next = count;
        case ({inc, dec_ok})
            2'b10:   count_next = count + CNT_W'(1);
            2'b01:   count_next = count - CNT_W'(1);
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clock) begin
        // NOTE: reset is sampled on the clock edge; sequential state uses <= only.
        if (reset) begin
            count           <= '0;
            underflow_error <= 1'b0;
        end else begin
            count <= count_next;
            if (dec && (count == '0))
                underflow_error <= 1'b1;
        end
    end

endmodule

// File: rtl/cu_array_cacheline_request_generator.sv
// Splits one array job (base, element count) into cacheline-aligned read
// requests with per-line element offset/count, bounded by response credits.
module cu_array_cacheline_request_generator
    import cu_array_cacheline_request_generator_pkg::*;
#(
    parameter  int         ELEMENT_SIZE    = 4,
    parameter  int         CACHELINE_SIZE  = 128,
    parameter  int         ADDR_WIDTH      = 64,
    parameter  int         COUNT_WIDTH     = 32,
    parameter  int         MAX_OUTSTANDING = 16,
    parameter  logic [7:0] CU_ID           = VERTEX_CONTROL_ID,
    localparam int         LINE_ELEMS      = int'(line_elems(CACHELINE_SIZE, ELEMENT_SIZE)),
    localparam int         OFF_W           = ($clog2(LINE_ELEMS) > 1) ? $clog2(LINE_ELEMS) : 1,
    localparam int         NUM_W           = $clog2(LINE_ELEMS) + 1,
    localparam int         CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   job_valid,
    output logic                   job_ready,
    input  logic [ADDR_WIDTH-1:0]  job_base_addr,
    input  logic [COUNT_WIDTH-1:0] job_num_elements,
    output logic                   req_valid,
    input  logic                   req_ready,
    output logic [ADDR_WIDTH-1:0]  req_addr,
    output logic [OFF_W-1:0]       req_offset,
    output logic [NUM_W-1:0]       req_num,
    output logic                   req_last,
    output logic [7:0]             req_cu_id,
    input  logic                   resp_valid,
    output logic [CNT_W-1:0]       outstanding,
    output logic                   job_done,
    output logic                   credit_error
);

    localparam int                    ES_SHIFT   = $clog2(ELEMENT_SIZE);
    localparam logic [ADDR_WIDTH-1:0] LINE_MOD   = ADDR_WIDTH'(line_mod_mask(CACHELINE_SIZE));
    localparam logic [ADDR_WIDTH-1:0] LINE_ALIGN = ADDR_WIDTH'(line_align_mask(CACHELINE_SIZE));
    localparam logic [ADDR_WIDTH-1:0] LINE_STEP  = ADDR_WIDTH'(CACHELINE_SIZE);

    req_gen_state_e         state_q;
    logic [COUNT_WIDTH-1:0] remaining;
    logic                   job_fire;
    logic                   req_fire;
    logic [OFF_W-1:0]       job_off;
    logic [NUM_W-1:0]       job_num;
    logic [COUNT_WIDTH-1:0] rem_after;
    logic [NUM_W-1:0]       next_num;
    logic [CNT_W-1:0]       count_next;
    logic                   credit_full;
    logic                   credit_avail_next;

    // Elements this line can carry: the smaller of what is left and what fits.
    function automatic logic [NUM_W-1:0] take(input logic [COUNT_WIDTH-1:0] rem,
                                              input logic [NUM_W-1:0]       room);
        if (rem < COUNT_WIDTH'(room))
            return NUM_W'(rem);
        return room;
    endfunction

    assign job_fire          = job_valid && job_ready;
    assign req_fire          = req_valid && req_ready;
    assign job_off           = OFF_W'((job_base_addr & LINE_MOD) >> ES_SHIFT);
    assign job_num           = take(job_num_elements, NUM_W'(LINE_ELEMS) - NUM_W'(job_off));
    assign rem_after         = remaining - COUNT_WIDTH'(req_num);
    assign next_num          = take(rem_after, NUM_W'(LINE_ELEMS));
    assign credit_avail_next = (count_next != CNT_W'(MAX_OUTSTANDING));
    assign req_cu_id         = CU_ID;

    cu_outstanding_credit_counter #(
        .MAX_OUTSTANDING(MAX_OUTSTANDING)
    ) u_credit (
        .clock          (clock),
        .reset          (reset),
        .inc            (req_fire && !credit_full),
        .dec            (resp_valid),
        .count          (outstanding),
        .count_next     (count_next),
        .full           (credit_full),
        .underflow_error(credit_error)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            job_ready  <= 1'b0;
            job_done   <= 1'b0;
            req_valid  <= 1'b0;
            req_addr   <= '0;
            req_offset <= '0;
            req_num    <= '0;
            req_last   <= 1'b0;
            remaining  <= '0;
        end else begin
            job_done <= 1'b0;
            case (state_q)
                IDLE: begin
                    job_ready <= !job_fire;
                    if (job_fire) begin
                        req_addr   <= job_base_addr & LINE_ALIGN;
                        req_offset <= job_off;
                        req_num    <= job_num;
                        req_last   <= (job_num_elements == COUNT_WIDTH'(job_num));
                        remaining  <= job_num_elements;
                        if (job_num_elements == '0) begin
                            state_q <= DRAIN;
                        end else begin
                            state_q   <= ISSUE;
                            req_valid <= credit_avail_next;
                        end
                    end
                end
                ISSUE: begin
                    // Credits only shrink on a handshake, so a held request never drops.
                    req_valid <= credit_avail_next && !(req_fire && req_last);
                    if (req_fire) begin
                        req_addr   <= req_addr + LINE_STEP;
                        req_offset <= '0;
                        req_num    <= next_num;
                        req_last   <= (rem_after == COUNT_WIDTH'(next_num));
                        remaining  <= rem_after;
                        if (req_last)
                            state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (outstanding == '0) begin
                        state_q   <= IDLE;
                        job_done  <= 1'b1;
                        job_ready <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cu_array_cacheline_request_generator.sv
// Directed bench: DUT a (4-byte elements, two credits) and DUT b (8-byte elements).
module tb_cu_array_cacheline_request_generator;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_ready;
    logic [63:0] job_base_addr;
    logic [31:0] job_num_elements;

    logic        job_valid_a, job_ready_a, req_valid_a, req_last_a, resp_valid_a;
    logic        job_done_a, credit_error_a;
    logic [63:0] req_addr_a;
    logic [4:0]  req_offset_a;
    logic [5:0]  req_num_a;
    logic [7:0]  req_cu_id_a;
    logic [1:0]  outstanding_a;

    logic        job_valid_b, job_ready_b, req_valid_b, req_last_b, resp_valid_b;
    logic        job_done_b, credit_error_b;
    logic [63:0] req_addr_b;
    logic [3:0]  req_offset_b;
    logic [4:0]  req_num_b;
    logic [7:0]  req_cu_id_b;
    logic [4:0]  outstanding_b;

    int errors = 0;
    int checks = 0;
    int hs;

    always #5 clock = ~clock;

    cu_array_cacheline_request_generator #(
        .ELEMENT_SIZE(4), .CACHELINE_SIZE(128), .ADDR_WIDTH(64), .COUNT_WIDTH(32),
        .MAX_OUTSTANDING(2), .CU_ID(8'h5A)
    ) dut_a (
        .clock(clock), .reset(reset),
        .job_valid(job_valid_a), .job_ready(job_ready_a),
        .job_base_addr(job_base_addr), .job_num_elements(job_num_elements),
        .req_valid(req_valid_a), .req_ready(req_ready),
        .req_addr(req_addr_a), .req_offset(req_offset_a), .req_num(req_num_a),
        .req_last(req_last_a), .req_cu_id(req_cu_id_a),
        .resp_valid(resp_valid_a), .outstanding(outstanding_a),
        .job_done(job_done_a), .credit_error(credit_error_a)
    );

    cu_array_cacheline_request_generator #(
        .ELEMENT_SIZE(8), .CACHELINE_SIZE(128), .ADDR_WIDTH(64), .COUNT_WIDTH(32),
        .MAX_OUTSTANDING(16), .CU_ID(8'h01)
    ) dut_b (
        .clock(clock), .reset(reset),
        .job_valid(job_valid_b), .job_ready(job_ready_b),
        .job_base_addr(job_base_addr), .job_num_elements(job_num_elements),
        .req_valid(req_valid_b), .req_ready(req_ready),
        .req_addr(req_addr_b), .req_offset(req_offset_b), .req_num(req_num_b),
        .req_last(req_last_b), .req_cu_id(req_cu_id_b),
        .resp_valid(resp_valid_b), .outstanding(outstanding_b),
        .job_done(job_done_b), .credit_error(credit_error_b)
    );

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(negedge clock);
    endtask

    task automatic check_req_a(input string tag, input logic [63:0] addr, input logic [63:0] off,
                               input logic [63:0] num, input logic [63:0] last);
        check({tag, ".valid"}, 64'(req_valid_a), 64'd1);
        check({tag, ".addr"},  req_addr_a, addr);
        check({tag, ".off"},   64'(req_offset_a), off);
        check({tag, ".num"},   64'(req_num_a), num);
        check({tag, ".last"},  64'(req_last_a), last);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; req_ready = 1'b0; job_base_addr = '0; job_num_elements = '0;
        job_valid_a = 1'b0; resp_valid_a = 1'b0; job_valid_b = 1'b0; resp_valid_b = 1'b0;

        // Reset cycle values
        step();
        check("rst.job_ready", 64'(job_ready_a), 64'd0);
        check("rst.req_valid", 64'(req_valid_a), 64'd0);
        check("rst.req_addr", req_addr_a, 64'd0);
        check("rst.req_num", 64'(req_num_a), 64'd0);
        check("rst.outstanding", 64'(outstanding_a), 64'd0);
        check("rst.job_done", 64'(job_done_a), 64'd0);
        check("rst.credit_error", 64'(credit_error_a), 64'd0);
        reset = 1'b0;
        step();
        check("post_rst.job_ready", 64'(job_ready_a), 64'd1);

        // Aligned single line: 0x1000, 32 elements
        job_valid_a = 1'b1; job_base_addr = 64'h1000; job_num_elements = 32; req_ready = 1'b1;
        step();
        job_valid_a = 1'b0;
        check_req_a("aligned", 64'h1000, 64'd0, 64'd32, 64'd1);
        check("aligned.cu_id", 64'(req_cu_id_a), 64'h5A);
        step();
        check("aligned.valid_after", 64'(req_valid_a), 64'd0);
        check("aligned.outstanding", 64'(outstanding_a), 64'd1);
        check("aligned.done_early", 64'(job_done_a), 64'd0);
        resp_valid_a = 1'b1;
        step();
        resp_valid_a = 1'b0;
        check("aligned.outstanding0", 64'(outstanding_a), 64'd0);
        check("aligned.done_wait", 64'(job_done_a), 64'd0);
        step();
        check("aligned.done", 64'(job_done_a), 64'd1);
        check("aligned.job_ready", 64'(job_ready_a), 64'd1);
        step();
        check("aligned.done_pulse", 64'(job_done_a), 64'd0);

        // Misaligned span 0x1078, 40 elements, with two credits
        job_valid_a = 1'b1; job_base_addr = 64'h1078; job_num_elements = 40;
        step();
        job_valid_a = 1'b0;
        check_req_a("span0", 64'h1000, 64'd30, 64'd2, 64'd0);
        step();
        check_req_a("span1", 64'h1080, 64'd0, 64'd32, 64'd0);
        step();
        check("span.stall_valid", 64'(req_valid_a), 64'd0);
        check("span.stall_outstanding", 64'(outstanding_a), 64'd2);
        resp_valid_a = 1'b1;
        step();
        check_req_a("span2", 64'h1100, 64'd0, 64'd6, 64'd1);
        check("span2.outstanding", 64'(outstanding_a), 64'd1);
        step();
        check("span.simul_outstanding", 64'(outstanding_a), 64'd1);
        check("span.valid_after_last", 64'(req_valid_a), 64'd0);
        step();
        resp_valid_a = 1'b0;
        check("span.outstanding0", 64'(outstanding_a), 64'd0);
        step();
        check("span.done", 64'(job_done_a), 64'd1);
        check("span.credit_error", 64'(credit_error_a), 64'd0);

        // Backpressure then credit stall: 0x0, 128 elements
        req_ready = 1'b0; job_valid_a = 1'b1; job_base_addr = 64'h0; job_num_elements = 128;
        step();
        job_valid_a = 1'b0;
        check_req_a("bp.first", 64'h0, 64'd0, 64'd32, 64'd0);
        for (int i = 0; i < 5; i++) begin
            step();
            check_req_a("bp.hold", 64'h0, 64'd0, 64'd32, 64'd0);
        end
        req_ready = 1'b1;
        hs = 0;
        for (int i = 0; i < 8; i++) begin
            if (req_valid_a) hs++;
            step();
        end
        check("stall.handshakes", 64'(hs), 64'd2);
        check("stall.outstanding", 64'(outstanding_a), 64'd2);
        check("stall.valid", 64'(req_valid_a), 64'd0);
        resp_valid_a = 1'b1;
        step();
        resp_valid_a = 1'b0;
        check_req_a("stall.third", 64'h100, 64'd0, 64'd32, 64'd0);

        // Reset mid-ISSUE, then a stale response
        reset = 1'b1;
        step();
        check("midrst.req_valid", 64'(req_valid_a), 64'd0);
        check("midrst.req_addr", req_addr_a, 64'd0);
        check("midrst.req_offset", 64'(req_offset_a), 64'd0);
        check("midrst.req_num", 64'(req_num_a), 64'd0);
        check("midrst.req_last", 64'(req_last_a), 64'd0);
        check("midrst.outstanding", 64'(outstanding_a), 64'd0);
        check("midrst.job_ready", 64'(job_ready_a), 64'd0);
        reset = 1'b0; resp_valid_a = 1'b1;
        step();
        resp_valid_a = 1'b0;
        check("spurious.credit_error", 64'(credit_error_a), 64'd1);
        check("spurious.outstanding", 64'(outstanding_a), 64'd0);
        check("spurious.job_ready", 64'(job_ready_a), 64'd1);

        // Zero-count job: job_done at T+2, no request
        job_valid_a = 1'b1; job_num_elements = 0;
        step();
        job_valid_a = 1'b0;
        check("zero.valid_t1", 64'(req_valid_a), 64'd0);
        check("zero.done_t1", 64'(job_done_a), 64'd0);
        step();
        check("zero.done_t2", 64'(job_done_a), 64'd1);
        check("zero.valid_t2", 64'(req_valid_a), 64'd0);
        step();
        check("zero.done_t3", 64'(job_done_a), 64'd0);

        // 8-byte elements: 0x40, 20 elements
        job_valid_b = 1'b1; job_base_addr = 64'h40; job_num_elements = 20;
        step();
        job_valid_b = 1'b0;
        check("es8.r0.valid", 64'(req_valid_b), 64'd1);
        check("es8.r0.addr", req_addr_b, 64'h0);
        check("es8.r0.off", 64'(req_offset_b), 64'd8);
        check("es8.r0.num", 64'(req_num_b), 64'd8);
        check("es8.r0.last", 64'(req_last_b), 64'd0);
        step();
        check("es8.r1.valid", 64'(req_valid_b), 64'd1);
        check("es8.r1.addr", req_addr_b, 64'h80);
        check("es8.r1.off", 64'(req_offset_b), 64'd0);
        check("es8.r1.num", 64'(req_num_b), 64'd12);
        check("es8.r1.last", 64'(req_last_b), 64'd1);
        check("es8.cu_id", 64'(req_cu_id_b), 64'h01);
        step();
        check("es8.valid_after", 64'(req_valid_b), 64'd0);
        check("es8.outstanding", 64'(outstanding_b), 64'd2);
        resp_valid_b = 1'b1;
        step();
        check("es8.outstanding1", 64'(outstanding_b), 64'd1);
        step();
        resp_valid_b = 1'b0;
        check("es8.outstanding0", 64'(outstanding_b), 64'd0);
        check("es8.done_wait", 64'(job_done_b), 64'd0);
        step();
        check("es8.done", 64'(job_done_b), 64'd1);
        check("es8.credit_error", 64'(credit_error_b), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
